// File: rtl/sseg4_scan_ctrl_if.sv
// Digit-register write port for the four-digit seven-segment scan controller.
// The master drives a write; the scan controller (slave) samples it on clk.
interface sseg4_scan_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_on;

  modport master (output wr_en, wr_addr, wr_data, wr_dp, wr_on);
  modport slave  (input  wr_en, wr_addr, wr_data, wr_dp, wr_on);
endinterface

// File: rtl/sseg4_scan_ctrl.sv
// Time-multiplexed scan of four common-anode seven-segment digits, with a
// dark guard interval at the start of every digit slot to suppress ghosting.
module sseg4_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic              clk,
  input  logic              reset,
  sseg4_scan_ctrl_if.slave  wr,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [3:0]        an,
  output logic              frame_tick
);

  localparam int            CW       = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       on;
  } digit_t;

  digit_t        digits [4];
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          slot_end;

  digit_t        cur;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_tick = slot_end && (idx == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // NOTE: the digit file is reset explicitly; after reset every digit must
  // read back dark, so these registers cannot be left uninitialised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) digits[i] <= '0;
    end else if (wr.wr_en) begin
      digits[wr.wr_addr] <= {wr.wr_data, wr.wr_dp, wr.wr_on};
    end
  end

  // NOTE: blocking assignments with defaults at the top keep this block
  // purely combinational; every path assigns every output, so no latches.
  always_comb begin
    cur   = digits[idx];
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (cnt >= CNT_SHOW) begin
      an_d[idx] = 1'b0;
      if (cur.on) begin
        seg_d = hex7(cur.value);
        dp_d  = ~cur.dp;
      end
    end
  end

  // Registered pins: at most one anode low, even across a slot boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_sseg4_scan_ctrl.sv
// Scoreboard bench for sseg4_scan_ctrl: directed writes, hand-computed pin
// values queued by cycle number, and a negedge monitor that pops and compares.
`timescale 1ns/1ps
module tb_sseg4_scan_ctrl;

  localparam int DC = 8;
  localparam int BC = 2;

  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S_0   = 7'b1000000;
  localparam logic [6:0] S_1   = 7'b1111001;
  localparam logic [6:0] S_3   = 7'b0110000;
  localparam logic [6:0] S_8   = 7'b0000000;
  localparam logic [6:0] S_A   = 7'b0001000;
  localparam logic [6:0] S_B   = 7'b0000011;
  localparam logic [6:0] S_C   = 7'b1000110;
  localparam logic [6:0] S_D   = 7'b0100001;
  localparam logic [6:0] S_F   = 7'b0001110;
  localparam logic [3:0][3:0] AN_SHOW = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  sseg4_scan_ctrl_if wr ();

  sseg4_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Edges seen since the last reset release; pins after edge n are item n.
  int cyc = 0;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  typedef struct {
    int         at;   // -1: expected while reset is held
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int at, input logic [3:0] a, input logic [6:0] s, input logic d);
    exp_t e;
    e.at  = at;
    e.an  = a;
    e.seg = s;
    e.dp  = d;
    exp_q.push_back(e);
  endtask

  task automatic push_slot(input int n0, input logic [1:0] s, input logic [6:0] sg, input logic d);
    for (int p = 0; p < DC; p++) begin
      if (p < BC) push(n0 + p, 4'b1111, S_OFF, 1'b1);
      else        push(n0 + p, AN_SHOW[s], sg, d);
    end
  endtask

  task automatic push_frame(input int n0, input logic [3:0][6:0] sg, input logic [3:0] d);
    for (int s = 0; s < 4; s++) push_slot(n0 + DC * s, 2'(s), sg[s], d[s]);
  endtask

  task automatic drive_wr(input logic en, input logic [1:0] a, input logic [3:0] v,
                          input logic pdp, input logic pon);
    wr.wr_en   = en;
    wr.wr_addr = a;
    wr.wr_data = v;
    wr.wr_dp   = pdp;
    wr.wr_on   = pon;
  endtask

  task automatic wait_cyc(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc != k && n < 400);
    check("wait_cyc", 16'(cyc), 16'(k));
  endtask

  // Monitor: invariants every cycle, then any scoreboard items due now.
  exp_t mon_e;
  bit   mon_done;
  always @(negedge clk) begin
    check("an_onehot", {15'd0, ($countones(~an) <= 1)}, 16'd1);
    check($sformatf("frame_tick@%0d", cyc), {15'd0, frame_tick},
          {15'd0, (!reset && (cyc % 32 == 31))});
    mon_done = 1'b0;
    while (!mon_done && exp_q.size() > 0) begin
      mon_e = exp_q[0];
      if (mon_e.at < 0) begin
        if (reset) begin
          void'(exp_q.pop_front());
          check("pins_in_reset", {4'd0, an, seg, dp}, {4'd0, mon_e.an, mon_e.seg, mon_e.dp});
        end
        mon_done = 1'b1;
      end else if (reset || mon_e.at > cyc) begin
        mon_done = 1'b1;
      end else begin
        void'(exp_q.pop_front());
        if (mon_e.at < cyc) check($sformatf("missed@%0d", mon_e.at), 16'(cyc), 16'(mon_e.at));
        else check($sformatf("pins@%0d", mon_e.at), {4'd0, an, seg, dp},
                   {4'd0, mon_e.an, mon_e.seg, mon_e.dp});
      end
    end
  end

  initial begin
    reset = 1'b0;
    drive_wr(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    push(-1, 4'b1111, S_OFF, 1'b1);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);

    // Dark frame, then C/8./0/F, then digit 2 disabled.
    push_frame(1,  {4{S_OFF}},             4'b1111);
    push_frame(33, {S_F, S_0, S_8, S_C},   4'b1101);
    push_frame(65, {S_F, S_OFF, S_8, S_C}, 4'b1101);
    // Frame 4: digit 0 rewritten to 3 on edge 101, reset lands in slot 2.
    push(97, 4'b1111, S_OFF, 1'b1);
    push(98, 4'b1111, S_OFF, 1'b1);
    for (int n = 99; n <= 101; n++) push(n, 4'b1110, S_C, 1'b1);
    for (int n = 102; n <= 104; n++) push(n, 4'b1110, S_3, 1'b1);
    push_slot(105, 2'd1, S_8, 1'b0);
    push(113, 4'b1111, S_OFF, 1'b1);
    push(114, 4'b1111, S_OFF, 1'b1);
    push(115, 4'b1011, S_OFF, 1'b1);
    push(116, 4'b1011, S_OFF, 1'b1);
    push(-1, 4'b1111, S_OFF, 1'b1);
    reset = 1'b0;

    wait_cyc(32); drive_wr(1'b1, 2'd0, 4'hC, 1'b0, 1'b1);
    wait_cyc(33); drive_wr(1'b1, 2'd1, 4'h8, 1'b1, 1'b1);
    wait_cyc(34); drive_wr(1'b1, 2'd2, 4'h0, 1'b0, 1'b1);
    wait_cyc(35); drive_wr(1'b1, 2'd3, 4'hF, 1'b0, 1'b1);
    wait_cyc(36); drive_wr(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);

    wait_cyc(68); drive_wr(1'b1, 2'd2, 4'h0, 1'b0, 1'b0);
    wait_cyc(69); drive_wr(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);

    wait_cyc(100); drive_wr(1'b1, 2'd0, 4'h3, 1'b0, 1'b1);
    wait_cyc(101); drive_wr(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);

    // Asynchronous reset between edges during slot 2 SHOW; writes while held are dropped.
    wait_cyc(116);
    @(posedge clk);
    #2 reset = 1'b1;
    drive_wr(1'b1, 2'd1, 4'h5, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive_wr(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    push_frame(1,  {4{S_OFF}},           4'b1111);
    push_frame(33, {S_D, S_B, S_A, S_1}, 4'b0110);
    push_frame(65, {S_D, S_B, S_A, S_1}, 4'b0110);
    push_frame(97, {S_D, S_B, S_A, S_1}, 4'b0110);
    reset = 1'b0;

    wait_cyc(32); drive_wr(1'b1, 2'd0, 4'h1, 1'b1, 1'b1);
    wait_cyc(33); drive_wr(1'b1, 2'd1, 4'hA, 1'b0, 1'b1);
    wait_cyc(34); drive_wr(1'b1, 2'd2, 4'hB, 1'b0, 1'b1);
    wait_cyc(35); drive_wr(1'b1, 2'd3, 4'hD, 1'b1, 1'b1);
    wait_cyc(36); drive_wr(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d items pending", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
